// File: rtl/port_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : port_frame_arbiter
// Purpose  : Per-output-port frame arbiter for the switch crossbar. Grants
//            whole frames round-robin, admits a frame only when the output
//            FIFO can hold a maximum-size frame, and force-releases a grant
//            when the granted source stalls.
// Revision : 1.0 - initial release
// ============================================================================
module port_frame_arbiter #(
  parameter int PORT_NUM        = 4,
  parameter int FIFO_DEPTH      = 1024,
  parameter int MAX_FRAME_WORDS = 384,
  parameter int TIMEOUT_CYC     = 4096
) (
  input  logic                glb_clk,
  input  logic                glb_areset,
  input  logic [PORT_NUM-1:0] req,
  input  logic [31:0]         fifo_space_used,
  input  logic                out_tvalid,
  input  logic                out_tready,
  input  logic                out_tlast,
  output logic [PORT_NUM-1:0] grant,
  output logic                grant_valid,
  output logic [15:0]         frame_cnt,
  output logic                timeout_err
);

  localparam int IDX_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [IDX_W-1:0]   C_LAST_RST  = IDX_W'(PORT_NUM - 1);
  localparam logic [STALL_W-1:0] C_STALL_MAX = STALL_W'(TIMEOUT_CYC - 1);

  logic [0:0]          state_q, state_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    last_idx_q, last_idx_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                timeout_q, timeout_d;

  logic [31:0]         free_w;
  logic                space_ok_w;
  logic                beat_w;
  logic                pick_found_w;
  logic [IDX_W-1:0]    pick_idx_w;

  // Free FIFO words, clamped at zero when the occupancy reads at/over depth.
  always_comb begin
    free_w = '0;
    if (fifo_space_used < 32'(FIFO_DEPTH)) begin
      free_w = 32'(FIFO_DEPTH) - fifo_space_used;
    end
  end

  assign space_ok_w = (free_w >= 32'(MAX_FRAME_WORDS));
  assign beat_w     = out_tvalid & out_tready;

  // Round-robin search starting one past the last served port.
  always_comb begin
    int j;
    j            = 0;
    pick_found_w = 1'b0;
    pick_idx_w   = last_idx_q;
    for (int k = 1; k <= PORT_NUM; k++) begin
      j = int'(last_idx_q) + k;
      if (j >= PORT_NUM) begin
        j = j - PORT_NUM;
      end
      if (!pick_found_w && req[j]) begin
        pick_found_w = 1'b1;
        pick_idx_w   = IDX_W'(j);
      end
    end
  end

  // Next-state logic: admission in IDLE, completion/watchdog in BUSY.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_idx_d  = last_idx_q;
    cur_idx_d   = cur_idx_q;
    stall_d     = stall_q;
    frame_cnt_d = frame_cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (space_ok_w && pick_found_w) begin
          grant_d             = '0;
          grant_d[pick_idx_w] = 1'b1;
          cur_idx_d           = pick_idx_w;
          stall_d             = '0;
          state_d             = S_BUSY;
        end
      end
      default: begin
        if (beat_w && out_tlast) begin
          // A completing beat wins over a simultaneous watchdog expiry.
          grant_d     = '0;
          last_idx_d  = cur_idx_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          stall_d     = '0;
          state_d     = S_IDLE;
        end else if (beat_w) begin
          stall_d = '0;
        end else if (stall_q == C_STALL_MAX) begin
          grant_d    = '0;
          last_idx_d = cur_idx_q;
          stall_d    = '0;
          timeout_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
    endcase
  end

  // State registers; reset drops the crossbar select immediately.
  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_idx_q  <= C_LAST_RST;
      cur_idx_q   <= '0;
      stall_q     <= '0;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_idx_q  <= last_idx_d;
      cur_idx_q   <= cur_idx_d;
      stall_q     <= stall_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_port_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_frame_arbiter
// Purpose  : Self-checking bench for port_frame_arbiter: table of vectors
//            plus hand-written watchdog and reset sequences, checked through
//            an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_port_frame_arbiter;

  logic        glb_clk;
  logic        glb_areset;
  logic [3:0]  req;
  logic [31:0] fifo_space_used;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [15:0] frame_cnt;
  logic        timeout_err;

  int checks;
  int errors;

  port_frame_arbiter #(
    .PORT_NUM        (4),
    .FIFO_DEPTH      (1024),
    .MAX_FRAME_WORDS (384),
    .TIMEOUT_CYC     (4096)
  ) dut (
    .glb_clk         (glb_clk),
    .glb_areset      (glb_areset),
    .req             (req),
    .fifo_space_used (fifo_space_used),
    .out_tvalid      (out_tvalid),
    .out_tready      (out_tready),
    .out_tlast       (out_tlast),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .frame_cnt       (frame_cnt),
    .timeout_err     (timeout_err)
  );

  initial glb_clk = 1'b0;
  always #5 glb_clk = ~glb_clk;

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] used;
    logic        v;
    logic        r;
    logic        l;
    logic [3:0]  eg;
    logic [15:0] ec;
    logic        eto;
  } vec_t;

  typedef struct {
    logic [3:0]  eg;
    logic [15:0] ec;
    logic        eto;
    string       nm;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  // Grant must never carry more than one bit.
  always @(negedge glb_clk) begin
    if (!$onehot0(grant)) begin
      errors++;
      $display("FAIL onehot grant=%b", grant);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] rq, input logic [31:0] used,
                              input logic v, input logic r, input logic l,
                              input logic [3:0] eg, input logic [15:0] ec, input logic eto);
    vec_t t;
    t.rq = rq; t.used = used; t.v = v; t.r = r; t.l = l;
    t.eg = eg; t.ec = ec; t.eto = eto;
    tbl.push_back(t);
  endfunction

  // Drive one cycle of inputs, then compare after the following rising edge.
  task automatic cyc(input logic [3:0] rq, input logic [31:0] used,
                     input logic v, input logic r, input logic l,
                     input logic [3:0] eg, input logic [15:0] ec, input logic eto,
                     input string nm);
    exp_t e;
    exp_t g;
    @(negedge glb_clk);
    req = rq; fifo_space_used = used;
    out_tvalid = v; out_tready = r; out_tlast = l;
    e.eg = eg; e.ec = ec; e.eto = eto; e.nm = nm;
    sb.push_back(e);
    @(posedge glb_clk);
    #1;
    g = sb.pop_front();
    chk({g.nm, ".grant"}, 32'(grant), 32'(g.eg));
    chk({g.nm, ".gvalid"}, 32'(grant_valid), 32'(|g.eg));
    chk({g.nm, ".cnt"}, 32'(frame_cnt), 32'(g.ec));
    chk({g.nm, ".tmo"}, 32'(timeout_err), 32'(g.eto));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    glb_areset = 1'b1;
    req = '0; fifo_space_used = '0;
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;

    // Single requester, 10-beat frame; req/space changes ignored while busy.
    add(4'b0100, 0, 0, 0, 0, 4'b0100, 0, 0);
    for (int i = 0; i < 9; i++) add(4'b1111, 2000, 1, 1, 0, 4'b0100, 0, 0);
    add(4'b0000, 0, 1, 1, 1, 4'b0000, 1, 0);
    // req=1011, 1-beat frames; pointer now at 2 so order is 3,0,1,3.
    add(4'b1011, 0, 0, 0, 0, 4'b1000, 1, 0);
    add(4'b1011, 0, 1, 1, 1, 4'b0000, 2, 0);
    add(4'b1011, 0, 0, 0, 0, 4'b0001, 2, 0);
    add(4'b1011, 0, 1, 1, 1, 4'b0000, 3, 0);
    add(4'b1011, 0, 0, 0, 0, 4'b0010, 3, 0);
    add(4'b1011, 0, 1, 1, 1, 4'b0000, 4, 0);
    add(4'b1011, 0, 0, 0, 0, 4'b1000, 4, 0);
    add(4'b1011, 0, 1, 1, 1, 4'b0000, 5, 0);
    // Space check: over-full, exactly full, free=383, then free=384.
    add(4'b0001, 2000, 0, 0, 0, 4'b0000, 5, 0);
    add(4'b0001, 1024, 0, 0, 0, 4'b0000, 5, 0);
    add(4'b0001, 641,  0, 0, 0, 4'b0000, 5, 0);
    add(4'b0001, 641,  0, 0, 0, 4'b0000, 5, 0);
    add(4'b0001, 640,  0, 0, 0, 4'b0001, 5, 0);
    // tlast without a full handshake is ignored.
    add(4'b0001, 0, 1, 0, 1, 4'b0001, 5, 0);
    add(4'b0001, 0, 0, 1, 1, 4'b0001, 5, 0);
    add(4'b0000, 0, 1, 1, 1, 4'b0000, 6, 0);

    repeat (3) @(posedge glb_clk);
    #1;
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.gvalid", 32'(grant_valid), 32'd0);
    chk("rst.cnt", 32'(frame_cnt), 32'd0);
    chk("rst.tmo", 32'(timeout_err), 32'd0);
    @(negedge glb_clk);
    glb_areset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rq, tbl[i].used, tbl[i].v, tbl[i].r, tbl[i].l,
          tbl[i].eg, tbl[i].ec, tbl[i].eto, $sformatf("tbl%0d", i));
    end

    // Watchdog: pointer at 0, req=0110 grants port 1, 4096 beatless cycles.
    cyc(4'b0110, 0, 0, 0, 0, 4'b0010, 6, 0, "to1.grant");
    for (int i = 0; i < 4095; i++) cyc(4'b0110, 0, 0, 0, 0, 4'b0010, 6, 0, "to1.hold");
    cyc(4'b0110, 0, 0, 0, 0, 4'b0000, 6, 1, "to1.fire");
    cyc(4'b0110, 0, 0, 0, 0, 4'b0100, 6, 0, "to1.next");
    // A mid-stall beat restarts the watchdog.
    for (int i = 0; i < 2000; i++) cyc(4'b0110, 0, 0, 0, 0, 4'b0100, 6, 0, "to2.pre");
    cyc(4'b0110, 0, 1, 1, 0, 4'b0100, 6, 0, "to2.beat");
    for (int i = 0; i < 4095; i++) cyc(4'b0110, 0, 0, 0, 0, 4'b0100, 6, 0, "to2.hold");
    cyc(4'b0110, 0, 0, 0, 0, 4'b0000, 6, 1, "to2.fire");
    // Completing beat on the expiry cycle wins over the watchdog.
    cyc(4'b0110, 0, 0, 0, 0, 4'b0010, 6, 0, "tw.grant");
    for (int i = 0; i < 4095; i++) cyc(4'b0110, 0, 0, 0, 0, 4'b0010, 6, 0, "tw.hold");
    cyc(4'b0110, 0, 1, 1, 1, 4'b0000, 7, 0, "tw.done");

    // Reset during beat 5: pointer at 1 so req=1111 grants port 2.
    cyc(4'b1111, 0, 0, 0, 0, 4'b0100, 7, 0, "rm.grant");
    for (int i = 0; i < 4; i++) cyc(4'b1111, 0, 1, 1, 0, 4'b0100, 7, 0, "rm.beat");
    @(negedge glb_clk);
    out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b0;
    #2;
    glb_areset = 1'b1;
    #1;
    chk("rm.async_grant", 32'(grant), 32'd0);
    chk("rm.async_gvalid", 32'(grant_valid), 32'd0);
    chk("rm.async_cnt", 32'(frame_cnt), 32'd0);
    @(negedge glb_clk);
    glb_areset = 1'b0;
    cyc(4'b1111, 0, 0, 0, 0, 4'b0001, 0, 0, "rm.first");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
